// File: rtl/adc_capture_bram_if.sv
// AXI-Stream beat bundle carrying ADC samples into the capture memory.
// The capture side is the slave and never back-pressures.
interface adc_capture_bram_if #(
    parameter int ADC_DATA_WIDTH = 256
);
    logic [ADC_DATA_WIDTH-1:0] tdata;
    logic                      tvalid;
    logic                      tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_capture_bram.sv
// Armed/triggered ADC capture into two 128-bit RAM banks with a 3-cycle
// GPIO readback path addressed by bank/row/16-bit lane.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | out of reset, waiting for an arm edge
// ARMED   | N latched, waiting for trigger; incoming beats discarded
// CAPTURE | each valid beat is written at waddr until N beats stored
// DONE    | capture finished, waiting for a re-arm edge
module adc_capture_bram #(
    parameter int GPIO_DATA_WIDTH = 16,
    parameter int ADC_DATA_WIDTH  = 256,
    parameter int RAM_DATA_WIDTH  = 128,
    parameter int RAM_ADDR_WIDTH  = 15,
    parameter int RAM_DEPTH       = 32768
) (
    input  logic                       s00_axis_aclk,
    input  logic                       s00_axis_areset,
    adc_capture_bram_if.slave          s00_axis,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic [31:0]                num_points,
    input  logic                       rd_bank,
    input  logic [RAM_ADDR_WIDTH-1:0]  rd_row,
    input  logic [2:0]                 rd_col,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_data_out,
    output logic                       busy,
    output logic                       capture_done,
    output logic [31:0]                beat_count
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      r_arm_q;
    logic                      w_arm_edge;
    logic                      w_arm_accept;
    logic                      w_we;
    logic [RAM_ADDR_WIDTH-1:0] r_waddr;
    logic [RAM_ADDR_WIDTH-1:0] r_last;
    logic [RAM_ADDR_WIDTH-1:0] w_last;
    logic [31:0]               r_beat_count;
    logic                      r_busy;
    logic                      r_done;

    logic [RAM_DATA_WIDTH-1:0] r_mem0 [RAM_DEPTH];
    logic [RAM_DATA_WIDTH-1:0] r_mem1 [RAM_DEPTH];
    logic [RAM_DATA_WIDTH-1:0] r_q0;
    logic [RAM_DATA_WIDTH-1:0] r_q1;
    logic [RAM_DATA_WIDTH-1:0] w_word;
    logic                      r_rd_bank;
    logic [RAM_ADDR_WIDTH-1:0] r_rd_row;
    logic [2:0]                r_rd_col;
    logic                      r_bank_d;
    logic [2:0]                r_col_d;
    logic [GPIO_DATA_WIDTH-1:0] r_gpio;

    assign s00_axis.tready = 1'b1;
    assign w_arm_edge      = arm & ~r_arm_q;
    assign w_arm_accept    = w_arm_edge & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_we            = (r_state == S_CAPTURE) & s00_axis.tvalid;

    // Store N-1 so the terminal compare is against the write address itself.
    always_comb begin
        w_last = '0;
        if (num_points == 32'd0)
            w_last = '0;
        else if (num_points > 32'(RAM_DEPTH))
            w_last = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);
        else
            w_last = RAM_ADDR_WIDTH'(num_points - 32'd1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_arm_edge) w_state_nxt = S_ARMED;
            S_ARMED:        if (trigger) w_state_nxt = S_CAPTURE;
            S_CAPTURE:      if (w_we && (r_waddr == r_last)) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_state      <= S_IDLE;
            r_arm_q      <= 1'b0;
            r_waddr      <= '0;
            r_last       <= '0;
            r_beat_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_arm_q <= arm;
            r_busy  <= (w_state_nxt == S_ARMED) | (w_state_nxt == S_CAPTURE);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_arm_accept) begin
                r_last       <= w_last;
                r_waddr      <= '0;
                r_beat_count <= '0;
            end else if (w_we) begin
                r_waddr      <= r_waddr + 1'b1;
                r_beat_count <= r_beat_count + 32'd1;
            end
        end
    end

    // Memory arrays carry no reset so they map onto block/ultra RAM; read-first.
    always_ff @(posedge s00_axis_aclk) begin
        if (w_we) begin
            r_mem0[r_waddr] <= s00_axis.tdata[RAM_DATA_WIDTH-1:0];
            r_mem1[r_waddr] <= s00_axis.tdata[ADC_DATA_WIDTH-1:RAM_DATA_WIDTH];
        end
        r_q0 <= r_mem0[r_rd_row];
        r_q1 <= r_mem1[r_rd_row];
    end

    assign w_word = r_bank_d ? r_q1 : r_q0;

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_bank_d  <= 1'b0;
            r_col_d   <= '0;
            r_gpio    <= '0;
        end else begin
            r_rd_bank <= rd_bank;
            r_rd_row  <= rd_row;
            r_rd_col  <= rd_col;
            r_bank_d  <= r_rd_bank;
            r_col_d   <= r_rd_col;
            r_gpio    <= w_word[{r_col_d, 4'b0000} +: GPIO_DATA_WIDTH];
        end
    end

    assign gpio_data_out = r_gpio;
    assign busy          = r_busy;
    assign capture_done  = r_done;
    assign beat_count    = r_beat_count;
endmodule

// File: tb/tb_adc_capture_bram.sv
// Randomised capture/readback bench for adc_capture_bram, checked every cycle
// against a behavioural model of the capture memory and status outputs.
module tb_adc_capture_bram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        trigger = 1'b0;
    logic [31:0] num_points = 32'd0;
    logic        rd_bank = 1'b0;
    logic [14:0] rd_row = '0;
    logic [2:0]  rd_col = '0;
    logic [15:0] gpio_data_out;
    logic        busy;
    logic        capture_done;
    logic [31:0] beat_count;

    int n_checks = 0;
    int n_err    = 0;

    adc_capture_bram_if #(.ADC_DATA_WIDTH(256)) axis_if ();

    adc_capture_bram dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis        (axis_if),
        .arm             (arm),
        .trigger         (trigger),
        .num_points      (num_points),
        .rd_bank         (rd_bank),
        .rd_row          (rd_row),
        .rd_col          (rd_col),
        .gpio_data_out   (gpio_data_out),
        .busy            (busy),
        .capture_done    (capture_done),
        .beat_count      (beat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lane(input logic [255:0] w, input logic b, input logic [2:0] c);
        logic [3:0] idx;
        idx = {b, c};
        return w[idx*16 +: 16];
    endfunction

    function automatic int clamp_n(input logic [31:0] np);
        if (np == 32'd0) return 1;
        if (np > 32'd32768) return 32768;
        return int'(np);
    endfunction

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_CAP = 2, PH_DONE = 3;
    int            m_phase = PH_IDLE;
    int            m_count = 0;
    int            m_n = 1;
    bit            m_arm_prev = 1'b0;
    bit            m_edge;
    logic [255:0]  m_mem [int];
    int            m_stable = 0;
    int            m_quiet = 0;
    logic [18:0]   m_addr_prev = '0;
    logic [18:0]   m_addr_now;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase    = PH_IDLE;
            m_count    = 0;
            m_arm_prev = 1'b0;
            m_stable   = 0;
            m_quiet    = 0;
        end else begin
            m_addr_now = {rd_bank, rd_row, rd_col};
            if (m_stable > 0 && m_addr_now == m_addr_prev) m_stable++;
            else m_stable = 1;
            m_addr_prev = m_addr_now;
            if (m_quiet < 1000) m_quiet++;
            m_edge     = arm && !m_arm_prev;
            m_arm_prev = arm;
            case (m_phase)
                PH_IDLE, PH_DONE: if (m_edge) begin
                    m_n     = clamp_n(num_points);
                    m_count = 0;
                    m_phase = PH_ARMED;
                end
                PH_ARMED: if (trigger) m_phase = PH_CAP;
                PH_CAP: if (axis_if.tvalid) begin
                    m_mem[m_count] = axis_if.tdata;
                    m_count++;
                    m_quiet = 0;
                    if (m_count == m_n) m_phase = PH_DONE;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("tready", {31'd0, axis_if.tready}, 32'd1);
            chk("busy", {31'd0, busy}, {31'd0, (m_phase == PH_ARMED || m_phase == PH_CAP)});
            chk("capture_done", {31'd0, capture_done}, {31'd0, (m_phase == PH_DONE)});
            chk("beat_count", beat_count, m_count);
            if (m_stable >= 3 && m_quiet >= 3 && m_mem.exists(int'(m_addr_prev[17:3])))
                chk("gpio_model", {16'd0, gpio_data_out},
                    {16'd0, lane(m_mem[int'(m_addr_prev[17:3])], m_addr_prev[18], m_addr_prev[2:0])});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] rnd_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [255:0] pat(input int i);
        logic [255:0] w;
        for (int k = 0; k < 16; k++) w[k*16 +: 16] = {i[7:0], k[7:0]};
        return w;
    endfunction

    task automatic beat(input logic [255:0] d, input bit v);
        axis_if.tdata  = d;
        axis_if.tvalid = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        axis_if.tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_done(input int lim, input int gap_mod);
        int k;
        k = 0;
        while (!capture_done && k < lim) begin
            beat(rnd_word(), $urandom_range(0, gap_mod - 1) != 0);
            k++;
        end
        axis_if.tvalid = 1'b0;
        if (!capture_done) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_done: capture_done still 0 after %0d cycles", lim);
        end
    endtask

    task automatic set_rd(input logic b, input logic [14:0] r, input logic [2:0] c);
        rd_bank = b;
        rd_row  = r;
        rd_col  = c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [255:0] first;

    initial begin
        axis_if.tdata  = '0;
        axis_if.tvalid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_tready", {31'd0, axis_if.tready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, capture_done}, 32'd0);
        chk("rst_count", beat_count, 32'd0);
        chk("rst_gpio", {16'd0, gpio_data_out}, 32'd0);
        rst = 1'b0;
        idle(2);

        // capture with gaps, N = 4
        num_points = 32'd4;
        pulse_arm();
        chk("gap_armed_busy", {31'd0, busy}, 32'd1);
        pulse_trig();
        beat(pat(0), 1'b1);
        beat(pat(1), 1'b1);
        beat('0, 1'b0);
        beat('0, 1'b0);
        beat(pat(2), 1'b1);
        chk("gap_not_done", {31'd0, capture_done}, 32'd0);
        chk("gap_count3", beat_count, 32'd3);
        beat(pat(3), 1'b1);
        axis_if.tvalid = 1'b0;
        chk("gap_done", {31'd0, capture_done}, 32'd1);
        chk("gap_busy", {31'd0, busy}, 32'd0);
        chk("gap_count", beat_count, 32'd4);
        set_rd(1'b0, 15'd0, 3'd0);
        idle(4);
        chk("gap_rd_row0", {16'd0, gpio_data_out}, 32'h0000);
        set_rd(1'b1, 15'd2, 3'd5);
        idle(2);
        chk("gap_rd_latency2", {16'd0, gpio_data_out}, 32'h0000);
        idle(1);
        chk("gap_rd_latency3", {16'd0, gpio_data_out}, 32'h020D);

        // pre-trigger discard
        num_points = 32'd3;
        pulse_arm();
        repeat (10) beat(rnd_word(), 1'b1);
        trigger = 1'b1;
        beat(rnd_word(), 1'b1);
        trigger = 1'b0;
        first = rnd_word();
        beat(first, 1'b1);
        wait_done(50, 2);
        set_rd(1'b0, 15'd0, 3'd0);
        idle(3);
        chk("pretrig_row0_lo", {16'd0, gpio_data_out}, {16'd0, first[15:0]});
        set_rd(1'b1, 15'd0, 3'd7);
        idle(3);
        chk("pretrig_row0_hi", {16'd0, gpio_data_out}, {16'd0, first[255:240]});

        // num_points = 0 clamps to one beat
        num_points = 32'd0;
        pulse_arm();
        pulse_trig();
        wait_done(50, 4);
        repeat (3) beat(rnd_word(), 1'b1);
        axis_if.tvalid = 1'b0;
        chk("clamp0_count", beat_count, 32'd1);
        chk("clamp0_done", {31'd0, capture_done}, 32'd1);

        // arm edge during capture is ignored
        num_points = 32'd8;
        pulse_arm();
        pulse_trig();
        repeat (3) beat(rnd_word(), 1'b1);
        arm = 1'b1;
        beat(rnd_word(), 1'b1);
        arm = 1'b0;
        wait_done(100, 3);
        chk("rearm_cap_count", beat_count, 32'd8);

        // re-arm from DONE
        num_points = 32'd5;
        pulse_arm();
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        chk("rearm_count", beat_count, 32'd0);
        num_points = 32'd100;
        pulse_trig();
        wait_done(100, 3);
        chk("rearm_n_latched", beat_count, 32'd5);
        for (int i = 0; i < 10; i++) begin
            set_rd(1'($urandom_range(0, 1)), 15'($urandom_range(0, 4)), 3'($urandom_range(0, 7)));
            idle(4);
        end

        // asynchronous reset mid-capture
        num_points = 32'd16;
        pulse_arm();
        pulse_trig();
        repeat (5) beat(rnd_word(), 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", beat_count, 32'd0);
        chk("midrst_gpio", {16'd0, gpio_data_out}, 32'd0);
        axis_if.tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        num_points = 32'd2;
        pulse_arm();
        pulse_trig();
        wait_done(50, 2);
        chk("postrst_count", beat_count, 32'd2);

        // oversize request clamps to full depth
        num_points = 32'd40000;
        pulse_arm();
        pulse_trig();
        wait_done(45000, 16);
        chk("big_count", beat_count, 32'd32768);
        repeat (5) beat(rnd_word(), 1'b1);
        axis_if.tvalid = 1'b0;
        chk("big_count_hold", beat_count, 32'd32768);
        set_rd(1'b1, 15'd32767, 3'd7);
        idle(4);
        set_rd(1'b0, 15'd0, 3'd0);
        idle(4);
        for (int i = 0; i < 30; i++) begin
            set_rd(1'($urandom_range(0, 1)), 15'($urandom_range(0, 32767)), 3'($urandom_range(0, 7)));
            idle(3 + $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
